// File: rtl/ret_addr_stack.sv
// Return address stack: speculative stack updated at fetch; optional committed stack restores it on flush.
// Define RAS_COMMIT_RECOVER_EN to build the committed stack; without it a flush simply empties the speculative stack.
`ifndef AddrWidth
`define AddrWidth 32
`endif

module ret_addr_stack #(
    parameter int ADDR  = `AddrWidth,
    parameter int DEPTH = 8,
    localparam int PTR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            push_,
    input  logic            pop_,
    input  logic [ADDR-1:0] push_addr,
    input  logic            com_push_,
    input  logic            com_pop_,
    input  logic [ADDR-1:0] com_addr,
    input  logic            flush_,
    output logic            ret_v,
    output logic [ADDR-1:0] ret_pc,
    output logic            ras_full
);

    localparam logic [PTR:0] CNT_FULL = (PTR+1)'(DEPTH);

    logic [ADDR-1:0] r_sp_arr [DEPTH];
    logic [PTR-1:0]  r_sp_tp;
    logic [PTR:0]    r_sp_cnt;

    logic            w_sp_we;
    logic [PTR-1:0]  w_sp_idx;
    logic [PTR-1:0]  w_sp_tp_nxt;
    logic [PTR:0]    w_sp_cnt_nxt;

    // A push+pop on an empty stack degenerates to a plain push.
    always_comb begin
        w_sp_we      = 1'b0;
        w_sp_idx     = r_sp_tp + PTR'(1);
        w_sp_tp_nxt  = r_sp_tp;
        w_sp_cnt_nxt = r_sp_cnt;
        if (!push_ && (pop_ || r_sp_cnt == '0)) begin
            w_sp_we      = 1'b1;
            w_sp_tp_nxt  = r_sp_tp + PTR'(1);
            w_sp_cnt_nxt = (r_sp_cnt == CNT_FULL) ? r_sp_cnt : r_sp_cnt + (PTR+1)'(1);
        end else if (!push_ && !pop_) begin
            w_sp_we  = 1'b1;
            w_sp_idx = r_sp_tp;
        end else if (!pop_ && r_sp_cnt != '0) begin
            w_sp_tp_nxt  = r_sp_tp - PTR'(1);
            w_sp_cnt_nxt = r_sp_cnt - (PTR+1)'(1);
        end
    end

`ifdef RAS_COMMIT_RECOVER_EN
    logic [ADDR-1:0] r_cm_arr [DEPTH];
    logic [PTR-1:0]  r_cm_tp;
    logic [PTR:0]    r_cm_cnt;

    logic            w_cm_we;
    logic [PTR-1:0]  w_cm_idx;
    logic [PTR-1:0]  w_cm_tp_nxt;
    logic [PTR:0]    w_cm_cnt_nxt;

    always_comb begin
        w_cm_we      = 1'b0;
        w_cm_idx     = r_cm_tp + PTR'(1);
        w_cm_tp_nxt  = r_cm_tp;
        w_cm_cnt_nxt = r_cm_cnt;
        if (!com_push_ && (com_pop_ || r_cm_cnt == '0)) begin
            w_cm_we      = 1'b1;
            w_cm_tp_nxt  = r_cm_tp + PTR'(1);
            w_cm_cnt_nxt = (r_cm_cnt == CNT_FULL) ? r_cm_cnt : r_cm_cnt + (PTR+1)'(1);
        end else if (!com_push_ && !com_pop_) begin
            w_cm_we  = 1'b1;
            w_cm_idx = r_cm_tp;
        end else if (!com_pop_ && r_cm_cnt != '0) begin
            w_cm_tp_nxt  = r_cm_tp - PTR'(1);
            w_cm_cnt_nxt = r_cm_cnt - (PTR+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_cm_tp  <= '0;
            r_cm_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_cm_arr[i] <= '0;
        end else begin
            r_cm_tp  <= w_cm_tp_nxt;
            r_cm_cnt <= w_cm_cnt_nxt;
            if (w_cm_we) r_cm_arr[w_cm_idx] <= com_addr;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, com_push_, com_pop_, com_addr};
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_sp_tp  <= '0;
            r_sp_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_sp_arr[i] <= '0;
        end else if (!flush_) begin
`ifdef RAS_COMMIT_RECOVER_EN
            // Restore from the commit stack including this cycle's commit update.
            r_sp_tp  <= w_cm_tp_nxt;
            r_sp_cnt <= w_cm_cnt_nxt;
            for (int i = 0; i < DEPTH; i++)
                r_sp_arr[i] <= (w_cm_we && w_cm_idx == PTR'(i)) ? com_addr : r_cm_arr[i];
`else
            r_sp_tp  <= '0;
            r_sp_cnt <= '0;
`endif
        end else begin
            r_sp_tp  <= w_sp_tp_nxt;
            r_sp_cnt <= w_sp_cnt_nxt;
            if (w_sp_we) r_sp_arr[w_sp_idx] <= push_addr;
        end
    end

    assign ret_v    = (r_sp_cnt != '0);
    assign ret_pc   = r_sp_arr[r_sp_tp];
    assign ras_full = (r_sp_cnt == CNT_FULL);

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: queue-based reference stacks feed a scoreboard of expected outputs.
module tb_ret_addr_stack;

    localparam int DEPTH = 8;

    typedef logic [31:0] addr_q_t [$];
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        push_ = 1'b1, pop_ = 1'b1, com_push_ = 1'b1, com_pop_ = 1'b1, flush_ = 1'b1;
    logic [31:0] push_addr = '0, com_addr = '0;
    logic        ret_v, ras_full;
    logic [31:0] ret_pc;

    int      n_cmp = 0;
    int      n_err = 0;
    exp_t    exp_q [$];
    addr_q_t m_spec;
    addr_q_t m_com;

    always #5 clk = ~clk;

    ret_addr_stack #(.ADDR(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_(reset_),
        .push_(push_), .pop_(pop_), .push_addr(push_addr),
        .com_push_(com_push_), .com_pop_(com_pop_), .com_addr(com_addr),
        .flush_(flush_),
        .ret_v(ret_v), .ret_pc(ret_pc), .ras_full(ras_full)
    );

    // Reference stack: newest entry at the back, oldest dropped when over capacity.
    function automatic addr_q_t upd(addr_q_t s, bit push, bit pop, logic [31:0] a);
        if (push && (!pop || s.size() == 0)) begin
            s.push_back(a);
            if (s.size() > DEPTH) void'(s.pop_front());
        end else if (push && pop) begin
            s[$] = a;
        end else if (pop && s.size() != 0) begin
            void'(s.pop_back());
        end
        return s;
    endfunction

    task automatic drive(input bit push, input bit pop, input logic [31:0] a,
                         input bit cpush, input bit cpop, input logic [31:0] ca, input bit flush);
        exp_t e;
        push_ = ~push; pop_ = ~pop; push_addr = a;
        com_push_ = ~cpush; com_pop_ = ~cpop; com_addr = ca;
        flush_ = ~flush;
        @(posedge clk);
`ifdef RAS_COMMIT_RECOVER_EN
        m_com = upd(m_com, cpush, cpop, ca);
        if (flush) m_spec = m_com;
        else       m_spec = upd(m_spec, push, pop, a);
`else
        if (flush) m_spec.delete();
        else       m_spec = upd(m_spec, push, pop, a);
`endif
        e.v    = (m_spec.size() != 0);
        e.pc   = e.v ? m_spec[$] : 32'h0;
        e.full = (m_spec.size() == DEPTH);
        exp_q.push_back(e);
        #1;
        push_ = 1'b1; pop_ = 1'b1; com_push_ = 1'b1; com_pop_ = 1'b1; flush_ = 1'b1;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (ret_v !== 1'b0 || ret_pc !== 32'h0 || ras_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got v=%b pc=%h full=%b, want v=0 pc=0 full=0", ret_v, ret_pc, ras_full);
        end
    endtask

    task automatic test_push_pop;
        exp_t e;
        logic [31:0] seq [3] = '{32'h100, 32'h200, 32'h300};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, 0, seq[i], 0, 0, 0, 0);
            else       drive(0, 1, 0, 0, 0, 0, 0);
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL push_pop[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
            if (i == 2) begin
                n_cmp++;
                if (ret_pc !== 32'h300) begin
                    n_err++;
                    $display("FAIL push_pop_top: got pc=%h, want 300", ret_pc);
                end
            end
        end
    endtask

    task automatic test_underflow;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(0, 1, 0, 0, 0, 0, 0);
            else       drive(1, 0, 32'h40, 0, 0, 0, 0);
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL underflow[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_wrap;
        exp_t e;
        for (int i = 0; i < 18; i++) begin
            if (i < 9) drive(1, 0, 32'h10 * (i + 1), 0, 0, 0, 0);
            else       drive(0, 1, 0, 0, 0, 0, 0);
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
        n_cmp++;
        if (ret_v !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_empty: got v=%b, want 0", ret_v);
        end
    endtask

    task automatic test_callret;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(1, 0, 32'h100, 0, 0, 0, 0);
                1:       drive(1, 1, 32'h500, 0, 0, 0, 0);
                2:       drive(0, 1, 0, 0, 0, 0, 0);
                3:       drive(1, 1, 32'h600, 0, 0, 0, 0);
                default: drive(0, 1, 0, 0, 0, 0, 0);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL callret[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
    endtask

    task automatic test_flush;
        exp_t e;
`ifdef RAS_COMMIT_RECOVER_EN
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive(0, 0, 0, 1, 0, 32'h100, 0);
                1:       drive(1, 0, 32'h200, 0, 0, 0, 0);
                2:       drive(1, 0, 32'h300, 0, 0, 0, 0);
                3:       drive(1, 0, 32'h700, 1, 0, 32'h400, 1);
                default: drive(0, 1, 0, 0, 1, 0, 0);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL flush[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1, 0, 32'h200, 1, 0, 32'h900, 0);
                1:       drive(1, 0, 32'h700, 0, 0, 0, 1);
                default: drive(0, 1, 0, 0, 0, 0, 0);
            endcase
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL flush[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
`endif
    endtask

    task automatic test_random;
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, {$urandom_range(16'hffff, 1), 2'b00},
                  $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, {$urandom_range(16'hffff, 1), 2'b00},
                  $urandom_range(9, 0) == 0);
            e = exp_q.pop_front();
            n_cmp++;
            if (ret_v !== e.v || (e.v && ret_pc !== e.pc) || ras_full !== e.full) begin
                n_err++;
                $display("FAIL random[%0d]: got v=%b pc=%h full=%b, want v=%b pc=%h full=%b",
                         i, ret_v, ret_pc, ras_full, e.v, e.pc, e.full);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 32'h1000 + 32'h4 * i, 1, 0, 32'h2000 + 32'h4 * i, 0);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (ras_full !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_pre: got full=%b, want 1", ras_full);
        end
        #2 reset_ = 1'b0;
        #1;
        n_cmp++;
        if (ret_v !== 1'b0 || ras_full !== 1'b0 || ret_pc !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b pc=%h full=%b, want v=0 pc=0 full=0", ret_v, ret_pc, ras_full);
        end
        m_spec.delete();
        m_com.delete();
        @(posedge clk);
        #1 reset_ = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_ = 1'b1;
        test_reset();
        test_push_pop();
        test_underflow();
        test_wrap();
        test_callret();
        test_flush();
        test_random();
        test_async_reset();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
